// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Registered data-memory access controller. Muxes the data
//               memory between the processor core (run mode) and an
//               external host that streams words in (load) or out (dump)
//               over valid/ready handshakes with auto-incrementing addresses.
//
// Ports       : clk, rst_n              clock / async active-low reset
//               status[1:0]             00 idle, 01 run, 10 load, 11 dump
//               core_we/addr/wdata      core write port (run mode)
//               host_base/len/start     stream setup (len = words - 1)
//               host_wvalid/wdata/wready  load-stream handshake
//               host_rvalid/rdata/rready  dump-stream handshake
//               dm_rdata                memory read data (1-cycle latency)
//               dm_en/addr/wdata        memory write enable / address / data
//               busy, done, err         stream status, sticky bounds error
//
// Option      : BOUNDS_CHECK_EN - reject streams and core accesses that run
//               past MEM_DEPTH and raise err; when undefined err is tied 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        status,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [ADDR_W-1:0] host_base,
    input  logic [ADDR_W-1:0] host_len,
    input  logic              host_start,
    input  logic              host_wvalid,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_wready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_rready,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dm_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_LD_WAIT   = 3'd2,
        S_LD_STREAM = 3'd3,
        S_DP_WAIT   = 3'd4,
        S_DP_READ   = 3'd5,
        S_DP_HOLD   = 3'd6
    } state_e;

    // Last addressable word; a stream touching it always completes.
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e              state_q, state_d;
    logic [1:0]          status_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic                dm_en_q, dm_en_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                w_mode_chg;
    logic                w_last;

    assign w_mode_chg = (status != status_q);
    // Stream ends on its final word or on the top of memory, whichever first.
    assign w_last     = (rem_q == '0) || (addr_q == C_LAST_ADDR);

`ifdef BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    logic              err_q, err_d;
    logic [ADDR_W:0]   w_span_end;
    logic              w_start_oob;
    logic              w_core_oob;

    // One extra bit so base+len cannot wrap below the limit.
    assign w_span_end  = {1'b0, host_base} + {1'b0, host_len};
    assign w_start_oob = (w_span_end >= C_DEPTH);
    assign w_core_oob  = ({1'b0, core_addr} >= C_DEPTH);
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

    // The cycle the mode changes is already an abort cycle, so no load beat
    // may be accepted in it.
    assign host_wready = (state_q == S_LD_STREAM) && !w_mode_chg;
    assign host_rvalid = host_rvalid_q;
    // The dump address is held for the whole DP_HOLD residency and memory is
    // never written in dump mode, so read data is stable while presented.
    assign host_rdata  = host_rvalid_q ? dm_rdata : {DATA_W{1'b0}};
    assign dm_en       = dm_en_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        dm_en_d       = 1'b0;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        host_rvalid_d = host_rvalid_q;
        busy_d        = busy_q;
        done_d        = done_q;
`ifdef BOUNDS_CHECK_EN
        err_d         = err_q;
`endif

        if (w_mode_chg) begin
            case (status)
                2'b00:   state_d = S_IDLE;
                2'b01:   state_d = S_RUN;
                2'b10:   state_d = S_LD_WAIT;
                default: state_d = S_DP_WAIT;
            endcase
            busy_d        = 1'b0;
            done_d        = 1'b0;
            host_rvalid_d = 1'b0;
`ifdef BOUNDS_CHECK_EN
            err_d         = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                end

                S_RUN: begin
                    dm_en_d    = core_we;
                    dm_addr_d  = core_addr;
                    dm_wdata_d = core_wdata;
`ifdef BOUNDS_CHECK_EN
                    if (w_core_oob) begin
                        dm_en_d = 1'b0;
                        err_d   = 1'b1;
                    end
`endif
                end

                S_LD_WAIT, S_DP_WAIT: begin
                    if (host_start) begin
`ifdef BOUNDS_CHECK_EN
                        if (w_start_oob) begin
                            err_d = 1'b1;
                        end else
`endif
                        begin
                            addr_d = host_base;
                            rem_d  = host_len;
                            busy_d = 1'b1;
                            done_d = 1'b0;
`ifdef BOUNDS_CHECK_EN
                            err_d  = 1'b0;
`endif
                            if (state_q == S_LD_WAIT) begin
                                state_d = S_LD_STREAM;
                            end else begin
                                // Address goes out on DP_READ entry so the
                                // memory has returned data by DP_HOLD.
                                dm_addr_d = host_base;
                                state_d   = S_DP_READ;
                            end
                        end
                    end
                end

                S_LD_STREAM: begin
                    if (host_wvalid) begin
                        dm_en_d    = 1'b1;
                        dm_addr_d  = addr_q;
                        dm_wdata_d = host_wdata;
                        addr_d     = addr_q + 1'b1;
                        if (w_last) begin
                            state_d = S_LD_WAIT;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end
                end

                S_DP_READ: begin
                    host_rvalid_d = 1'b1;
                    state_d       = S_DP_HOLD;
                end

                S_DP_HOLD: begin
                    if (host_rvalid_q && host_rready) begin
                        host_rvalid_d = 1'b0;
                        if (w_last) begin
                            state_d = S_DP_WAIT;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d    = addr_q + 1'b1;
                            rem_d     = rem_q - 1'b1;
                            dm_addr_d = addr_q + 1'b1;
                            state_d   = S_DP_READ;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            status_q      <= 2'b00;
            addr_q        <= '0;
            rem_q         <= '0;
            dm_en_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            host_rvalid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            dm_en_q       <= dm_en_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            host_rvalid_q <= host_rvalid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule
`default_nettype wire
